// File: rtl/video_vram_port_if.sv
`default_nettype none
// ============================================================================
//  Module : video_vram_port_if
//  Brief  : Host strobe / video bus bundle for the PPU VRAM access stage.
//  Rev    : 1.0  initial release
// ============================================================================
interface video_vram_port_if #(
    parameter int P_ADDR_WIDTH = 14
);
    logic                    I_tick;
    logic [7:0]              I_host_data;
    logic                    I_wr_ctrl;
    logic                    I_wr_scrl;
    logic                    I_wr_addr;
    logic                    I_wr_data;
    logic                    I_rd_data;
    logic                    I_rd_stat;
    logic [7:0]              O_rd_buffer;
    logic [P_ADDR_WIDTH-1:0] O_vid_addr;
    logic                    O_vid_wren;
    logic [7:0]              O_vid_data;
    logic [7:0]              I_vid_data;
    logic                    O_busy;
    logic                    O_overrun;
    logic [14:0]             O_t;
    logic [14:0]             O_v;
    logic [2:0]              O_fine_x;

    modport slave (
        input  I_tick, I_host_data, I_wr_ctrl, I_wr_scrl, I_wr_addr,
               I_wr_data, I_rd_data, I_rd_stat, I_vid_data,
        output O_rd_buffer, O_vid_addr, O_vid_wren, O_vid_data,
               O_busy, O_overrun, O_t, O_v, O_fine_x
    );

    modport master (
        output I_tick, I_host_data, I_wr_ctrl, I_wr_scrl, I_wr_addr,
               I_wr_data, I_rd_data, I_rd_stat, I_vid_data,
        input  O_rd_buffer, O_vid_addr, O_vid_wren, O_vid_data,
               O_busy, O_overrun, O_t, O_v, O_fine_x
    );
endinterface
`default_nettype wire

// File: rtl/video_vram_port.sv
`default_nettype none
// ============================================================================
//  Module : video_vram_port
//  Brief  : PPU scroll/address registers (t, v, fine-x, w) and paced PPUDATA
//           read/write sequencer on the video memory bus.
//  Rev    : 1.0  initial release
// ============================================================================
module video_vram_port #(
    parameter int P_ADDR_WIDTH = 14,
    parameter int P_INC_LARGE  = 32
) (
    input  wire logic          I_clock,
    input  wire logic          I_reset,
    video_vram_port_if.slave   bus
);
    localparam logic [1:0]  c_idle     = 2'd0;
    localparam logic [1:0]  c_arm      = 2'd1;
    localparam logic [1:0]  c_complete = 2'd2;
    localparam logic [14:0] c_inc_large = 15'(P_INC_LARGE);
    localparam logic [14:0] c_inc_small = 15'd1;

    logic [1:0]  r_state;
    logic [14:0] r_t;
    logic [14:0] r_v;
    logic [2:0]  r_fine_x;
    logic        r_w;
    logic        r_inc32;
    logic        r_op_write;
    logic [7:0]  r_rd_buffer;
    logic [7:0]  r_vid_data;
    logic        r_vid_wren;
    logic        r_overrun;

    logic [14:0] w_t_next;
    logic [14:0] w_v_base;
    logic [14:0] w_v_next;
    logic [2:0]  w_fine_x_next;
    logic        w_w_next;
    logic        w_w_eff;
    logic        w_inc32_next;
    logic        w_load_v;
    logic        w_busy;
    logic        w_step;

    assign w_busy  = (r_state != c_idle);
    // A status read clears w before any coincident SCRL/ADDR write is decoded.
    assign w_w_eff = r_w & ~bus.I_rd_stat;
    assign w_step  = (r_state == c_complete) & bus.I_tick;

    always_comb begin
        w_t_next      = r_t;
        w_fine_x_next = r_fine_x;
        w_w_next      = w_w_eff;
        w_inc32_next  = r_inc32;
        w_load_v      = 1'b0;
        if (bus.I_wr_ctrl) begin
            w_t_next[11:10] = bus.I_host_data[1:0];
            w_inc32_next    = bus.I_host_data[2];
        end
        if (bus.I_wr_scrl) begin
            if (!w_w_eff) begin
                w_t_next[4:0] = bus.I_host_data[7:3];
                w_fine_x_next = bus.I_host_data[2:0];
                w_w_next      = 1'b1;
            end else begin
                w_t_next[14:12] = bus.I_host_data[2:0];
                w_t_next[9:5]   = bus.I_host_data[7:3];
                w_w_next        = 1'b0;
            end
        end
        if (bus.I_wr_addr) begin
            if (!w_w_eff) begin
                w_t_next[13:8] = bus.I_host_data[5:0];
                w_t_next[14]   = 1'b0;
                w_w_next       = 1'b1;
            end else begin
                w_t_next[7:0] = bus.I_host_data;
                w_load_v      = 1'b1;
                w_w_next      = 1'b0;
            end
        end
        // A pending increment lands on whatever v the same edge produces.
        w_v_base = w_load_v ? w_t_next : r_v;
        w_v_next = w_step ? (w_v_base + (r_inc32 ? c_inc_large : c_inc_small))
                          : w_v_base;
    end

    always_ff @(posedge I_clock) begin
        if (!I_reset) begin
            r_state     <= c_idle;
            r_t         <= '0;
            r_v         <= '0;
            r_fine_x    <= '0;
            r_w         <= 1'b0;
            r_inc32     <= 1'b0;
            r_op_write  <= 1'b0;
            r_rd_buffer <= '0;
            r_vid_data  <= '0;
            r_vid_wren  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_t        <= w_t_next;
            r_v        <= w_v_next;
            r_fine_x   <= w_fine_x_next;
            r_w        <= w_w_next;
            r_inc32    <= w_inc32_next;
            r_vid_wren <= 1'b0;
            r_overrun  <= (bus.I_wr_data | bus.I_rd_data) & w_busy;
            case (r_state)
                c_idle: begin
                    if (bus.I_wr_data) begin
                        r_vid_data <= bus.I_host_data;
                        r_op_write <= 1'b1;
                        r_state    <= c_arm;
                    end else if (bus.I_rd_data) begin
                        r_op_write <= 1'b0;
                        r_state    <= c_arm;
                    end
                end
                c_arm: begin
                    if (bus.I_tick) begin
                        r_vid_wren <= r_op_write;
                        r_state    <= c_complete;
                    end
                end
                c_complete: begin
                    if (bus.I_tick) begin
                        if (!r_op_write) begin
                            r_rd_buffer <= bus.I_vid_data;
                        end
                        r_state <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign bus.O_vid_addr  = r_v[P_ADDR_WIDTH-1:0];
    assign bus.O_vid_wren  = r_vid_wren;
    assign bus.O_vid_data  = r_vid_data;
    assign bus.O_rd_buffer = r_rd_buffer;
    assign bus.O_busy      = w_busy;
    assign bus.O_overrun   = r_overrun;
    assign bus.O_t         = r_t;
    assign bus.O_v         = r_v;
    assign bus.O_fine_x    = r_fine_x;
endmodule
`default_nettype wire

// File: tb/tb_video_vram_port.sv
`default_nettype none
// ============================================================================
//  Module : tb_video_vram_port
//  Brief  : Directed self-checking bench for video_vram_port.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_video_vram_port;
    localparam int K_CTRL = 1, K_SCRL = 2, K_ADDR = 3, K_WDAT = 4, K_RDAT = 5, K_NONE = 0;

    logic clk;
    logic rst_n;
    logic [7:0] mem [0:16383];
    int   total = 0;
    int   bad = 0;
    int   wren_cnt = 0;
    int   ovr_cnt = 0;
    logic [13:0] last_addr = '0;
    logic [7:0]  last_data = '0;

    video_vram_port_if #(.P_ADDR_WIDTH(14)) vif ();

    video_vram_port #(.P_ADDR_WIDTH(14), .P_INC_LARGE(32)) dut (
        .I_clock (clk),
        .I_reset (rst_n),
        .bus     (vif)
    );

    assign vif.I_vid_data = mem[vif.O_vid_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pixel tick: one cycle high out of every four.
    initial begin
        vif.I_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            vif.I_tick = 1'b1;
            @(negedge clk);
            vif.I_tick = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (vif.O_vid_wren) begin
            wren_cnt  <= wren_cnt + 1;
            last_addr <= vif.O_vid_addr;
            last_data <= vif.O_vid_data;
        end
        if (vif.O_overrun) ovr_cnt <= ovr_cnt + 1;
    end

    task automatic strobe(input int kind, input logic [7:0] d, input logic stat);
        @(negedge clk); #1;
        vif.I_host_data = d;
        vif.I_wr_ctrl = (kind == K_CTRL);
        vif.I_wr_scrl = (kind == K_SCRL);
        vif.I_wr_addr = (kind == K_ADDR);
        vif.I_wr_data = (kind == K_WDAT);
        vif.I_rd_data = (kind == K_RDAT);
        vif.I_rd_stat = stat;
        @(negedge clk); #1;
        vif.I_wr_ctrl = 1'b0; vif.I_wr_scrl = 1'b0; vif.I_wr_addr = 1'b0;
        vif.I_wr_data = 1'b0; vif.I_rd_data = 1'b0; vif.I_rd_stat = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (!vif.O_busy) begin done = 1'b1; break; end
        end
        total++;
        if (!done) begin bad++; $display("FAIL idle_timeout: busy=%b required=0", vif.O_busy); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk); #1;
        total++; if (vif.O_t !== 15'h0)       begin bad++; $display("FAIL rst_t: got %h want 0", vif.O_t); end
        total++; if (vif.O_v !== 15'h0)       begin bad++; $display("FAIL rst_v: got %h want 0", vif.O_v); end
        total++; if (vif.O_fine_x !== 3'h0)   begin bad++; $display("FAIL rst_fx: got %h want 0", vif.O_fine_x); end
        total++; if (vif.O_busy !== 1'b0)     begin bad++; $display("FAIL rst_busy: got %b want 0", vif.O_busy); end
        total++; if (vif.O_vid_wren !== 1'b0) begin bad++; $display("FAIL rst_wren: got %b want 0", vif.O_vid_wren); end
        total++; if (vif.O_overrun !== 1'b0)  begin bad++; $display("FAIL rst_ovr: got %b want 0", vif.O_overrun); end
        total++; if (vif.O_rd_buffer !== 8'h0) begin bad++; $display("FAIL rst_rdbuf: got %h want 0", vif.O_rd_buffer); end
        total++; if (vif.O_vid_data !== 8'h0) begin bad++; $display("FAIL rst_vdata: got %h want 0", vif.O_vid_data); end
        rst_n = 1'b1;
    endtask

    task automatic test_addr();
        strobe(K_ADDR, 8'h21, 1'b0);
        strobe(K_ADDR, 8'h08, 1'b0);
        total++; if (vif.O_t !== 15'h2108)        begin bad++; $display("FAIL addr_t: got %h want 2108", vif.O_t); end
        total++; if (vif.O_v !== 15'h2108)        begin bad++; $display("FAIL addr_v: got %h want 2108", vif.O_v); end
        total++; if (vif.O_vid_addr !== 14'h2108) begin bad++; $display("FAIL addr_bus: got %h want 2108", vif.O_vid_addr); end
    endtask

    task automatic test_write_inc32();
        int w0;
        strobe(K_CTRL, 8'h04, 1'b0);
        strobe(K_ADDR, 8'h20, 1'b0);
        strobe(K_ADDR, 8'h00, 1'b0);
        w0 = wren_cnt;
        strobe(K_WDAT, 8'hAB, 1'b0);
        total++; if (vif.O_busy !== 1'b1) begin bad++; $display("FAIL wr_busy: got %b want 1", vif.O_busy); end
        wait_idle();
        total++; if (wren_cnt - w0 !== 1)    begin bad++; $display("FAIL wr_wren_cycles: got %0d want 1", wren_cnt - w0); end
        total++; if (last_addr !== 14'h2000) begin bad++; $display("FAIL wr_addr: got %h want 2000", last_addr); end
        total++; if (last_data !== 8'hAB)    begin bad++; $display("FAIL wr_data: got %h want ab", last_data); end
        total++; if (vif.O_v !== 15'h2020)   begin bad++; $display("FAIL wr_v_inc32: got %h want 2020", vif.O_v); end
    endtask

    task automatic test_read();
        strobe(K_CTRL, 8'h00, 1'b0);
        strobe(K_ADDR, 8'h24, 1'b0);
        strobe(K_ADDR, 8'h00, 1'b0);
        strobe(K_RDAT, 8'h00, 1'b0);
        total++; if (vif.O_rd_buffer !== 8'h00) begin bad++; $display("FAIL rd1_stale: got %h want 00", vif.O_rd_buffer); end
        wait_idle();
        total++; if (vif.O_rd_buffer !== 8'h5A) begin bad++; $display("FAIL rd1_buf: got %h want 5a", vif.O_rd_buffer); end
        strobe(K_RDAT, 8'h00, 1'b0);
        total++; if (vif.O_rd_buffer !== 8'h5A) begin bad++; $display("FAIL rd2_hold: got %h want 5a", vif.O_rd_buffer); end
        wait_idle();
        total++; if (vif.O_rd_buffer !== 8'h3C) begin bad++; $display("FAIL rd2_buf: got %h want 3c", vif.O_rd_buffer); end
        total++; if (vif.O_v !== 15'h2402)      begin bad++; $display("FAIL rd_v: got %h want 2402", vif.O_v); end
    endtask

    task automatic test_scroll_toggle();
        strobe(K_SCRL, 8'h7D, 1'b0);
        strobe(K_SCRL, 8'h5E, 1'b0);
        total++; if (vif.O_fine_x !== 3'd5)  begin bad++; $display("FAIL scrl_fx: got %h want 5", vif.O_fine_x); end
        total++; if (vif.O_t !== 15'h656F)   begin bad++; $display("FAIL scrl_t: got %h want 656f", vif.O_t); end
        // Status read coincident with an ADDR write: decoded as a first write.
        strobe(K_ADDR, 8'h15, 1'b0);
        strobe(K_ADDR, 8'h2A, 1'b1);
        total++; if (vif.O_t !== 15'h2A6F)   begin bad++; $display("FAIL stat_coinc_t: got %h want 2a6f", vif.O_t); end
        total++; if (vif.O_v !== 15'h2402)   begin bad++; $display("FAIL stat_coinc_v: got %h want 2402", vif.O_v); end
        strobe(K_NONE, 8'h00, 1'b1);
        strobe(K_ADDR, 8'h3F, 1'b0);
        total++; if (vif.O_t !== 15'h3F6F)   begin bad++; $display("FAIL stat_t: got %h want 3f6f", vif.O_t); end
        total++; if (vif.O_v !== 15'h2402)   begin bad++; $display("FAIL stat_v: got %h want 2402", vif.O_v); end
        strobe(K_ADDR, 8'hFF, 1'b0);
        total++; if (vif.O_v !== 15'h3FFF)   begin bad++; $display("FAIL stat_w1_v: got %h want 3fff", vif.O_v); end
    endtask

    task automatic test_wrap();
        strobe(K_WDAT, 8'h77, 1'b0);
        wait_idle();
        total++; if (last_addr !== 14'h3FFF)     begin bad++; $display("FAIL wrap14_wraddr: got %h want 3fff", last_addr); end
        total++; if (vif.O_v !== 15'h4000)       begin bad++; $display("FAIL wrap14_v: got %h want 4000", vif.O_v); end
        total++; if (vif.O_vid_addr !== 14'h0)   begin bad++; $display("FAIL wrap14_bus: got %h want 0000", vif.O_vid_addr); end
        strobe(K_CTRL, 8'h03, 1'b0);
        strobe(K_SCRL, 8'h00, 1'b0);
        strobe(K_SCRL, 8'hFF, 1'b0);
        strobe(K_SCRL, 8'h00, 1'b0);
        strobe(K_ADDR, 8'hFF, 1'b0);
        total++; if (vif.O_v !== 15'h7FFF)       begin bad++; $display("FAIL wrap15_load: got %h want 7fff", vif.O_v); end
        strobe(K_RDAT, 8'h00, 1'b0);
        wait_idle();
        total++; if (vif.O_v !== 15'h0000)       begin bad++; $display("FAIL wrap15_v: got %h want 0000", vif.O_v); end
    endtask

    task automatic test_overrun();
        int w0, o0;
        strobe(K_CTRL, 8'h00, 1'b0);
        w0 = wren_cnt;
        o0 = ovr_cnt;
        strobe(K_WDAT, 8'h11, 1'b0);
        strobe(K_WDAT, 8'h22, 1'b0);
        wait_idle();
        total++; if (ovr_cnt - o0 !== 1)   begin bad++; $display("FAIL ovr_pulses: got %0d want 1", ovr_cnt - o0); end
        total++; if (wren_cnt - w0 !== 1)  begin bad++; $display("FAIL ovr_wrens: got %0d want 1", wren_cnt - w0); end
        total++; if (last_data !== 8'h11)  begin bad++; $display("FAIL ovr_data: got %h want 11", last_data); end
        total++; if (vif.O_v !== 15'h0001) begin bad++; $display("FAIL ovr_v: got %h want 0001", vif.O_v); end
    endtask

    task automatic test_reset_in_arm();
        int  w0;
        bit  got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (vif.I_tick) begin got = 1'b1; break; end
        end
        total++; if (!got) begin bad++; $display("FAIL arm_sync: tick=%b required=1", vif.I_tick); end
        w0 = wren_cnt;
        vif.I_host_data = 8'h99;
        vif.I_wr_data = 1'b1;
        @(negedge clk); #1;
        vif.I_wr_data = 1'b0;
        total++; if (vif.O_busy !== 1'b1) begin bad++; $display("FAIL arm_busy: got %b want 1", vif.O_busy); end
        rst_n = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        total++; if (vif.O_busy !== 1'b0) begin bad++; $display("FAIL arm_rst_busy: got %b want 0", vif.O_busy); end
        repeat (10) @(negedge clk); #1;
        total++; if (wren_cnt - w0 !== 0) begin bad++; $display("FAIL arm_rst_wren: got %0d want 0", wren_cnt - w0); end
        total++; if (vif.O_v !== 15'h0)   begin bad++; $display("FAIL arm_rst_v: got %h want 0", vif.O_v); end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        mem[14'h2400] = 8'h5A;
        mem[14'h2401] = 8'h3C;
        rst_n = 1'b0;
        vif.I_host_data = 8'h00;
        vif.I_wr_ctrl = 1'b0; vif.I_wr_scrl = 1'b0; vif.I_wr_addr = 1'b0;
        vif.I_wr_data = 1'b0; vif.I_rd_data = 1'b0; vif.I_rd_stat = 1'b0;
        test_reset();
        test_addr();
        test_write_inc32();
        test_read();
        test_scroll_toggle();
        test_wrap();
        test_overrun();
        test_reset_in_arm();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/video_vram_port.md
Name: video_vram_port

Overview:
- Host-side VRAM access stage of the PPU. It sits between the register decoder strobes and the video memory bus.
- Implements the PPUSCROLL/PPUADDR/PPUDATA address machinery: the t, v, fine-x registers and the w toggle.
- Performs paced PPUDATA reads and writes on the video bus, gated by the pixel-clock tick.
- Exports the scroll/address state to the renderer.

Parameters:
P_addr_width, 14, width of video bus address driven from v.
P_inc_large, 32, address increment used when PPUCTRL bit 2 is set.

Ports:
I_clock  in  1  system clock
I_reset  in  1  synchronous reset, active-low
I_tick  in  1  video clock-enable (pixel rise); paces bus accesses
I_host_data  in  8  latched host write data
I_wr_ctrl  in  1  one-cycle strobe: PPUCTRL write
I_wr_scrl  in  1  one-cycle strobe: PPUSCROLL write
I_wr_addr  in  1  one-cycle strobe: PPUADDR write
I_wr_data  in  1  one-cycle strobe: PPUDATA write
I_rd_data  in  1  one-cycle strobe: PPUDATA read
I_rd_stat  in  1  one-cycle strobe: PPUSTATUS read (clears w)
O_rd_buffer  out  8  PPUDATA read buffer presented to host mux
O_vid_addr  out  14  video bus address
O_vid_wren  out  1  video bus write enable
O_vid_data  out  8  video bus write data
I_vid_data  in  8  video bus read data
O_busy  out  1  PPUDATA access in flight
O_overrun  out  1  one-cycle pulse: PPUDATA strobe dropped while busy
O_t  out  15  temporary address register t
O_v  out  15  current address register v
O_fine_x  out  3  fine X scroll

Behaviour:
- Reset (I_reset low at a rising edge): t, v, fine_x, w, rd_buffer, O_vid_data = 0; inc32 = 0; O_vid_wren = 0; O_busy = 0; O_overrun = 0; state IDLE. Reset mid-access aborts the access; no wren pulse is issued and v is not incremented.
- All register updates occur on the I_clock edge where the strobe is high. Strobes are one-hot, except I_rd_stat, which may coincide with any other strobe.
- PPUCTRL write: t[11:10] = d[1:0]; inc32 = d[2].
- PPUSCROLL write:
  - w=0: t[4:0] = d[7:3]; fine_x = d[2:0]; w = 1.
  - w=1: t[14:12] = d[2:0]; t[9:5] = d[7:3]; w = 0.
- PPUADDR write:
  - w=0: t[13:8] = d[5:0]; t[14] = 0; w = 1.
  - w=1: t[7:0] = d; v = new t (same edge); w = 0.
- I_rd_stat: w = 0. If it coincides with a SCRL/ADDR write, the write is decoded with w=0 and w ends at 1.
- O_vid_addr = v[13:0] combinationally at all times. O_t, O_v, O_fine_x are direct register outputs.
- FSM states:
  - IDLE: on I_wr_data, latch O_vid_data = d, set op = WRITE, go to ARM. On I_rd_data, set op = READ, go to ARM. O_busy = 0.
  - ARM: wait for I_tick. On I_tick, register O_vid_wren = (op == WRITE), high for exactly one I_clock cycle; go to COMPLETE.
  - COMPLETE: wait for the next I_tick. On it:
    - if READ, rd_buffer = I_vid_data;
    - v = v + (inc32 ? 32 : 1), mod 2^15;
    - go to IDLE.
- O_busy = 1 in ARM and COMPLETE.
- A PPUDATA strobe while busy is ignored, and O_overrun pulses for one cycle. An SCRL/ADDR/CTRL write while busy updates t/w/inc32 immediately. An ADDR second write while busy loads v, and the pending increment then applies to the new v.
- O_rd_buffer holds the previous value during a read. It changes only in COMPLETE (delayed-read semantics; the first read after setting an address returns stale data).
- Access latency: 2 I_tick periods from strobe to IDLE.
- Wrap: v = 0x7FFF + 1 gives 0x0000. O_vid_addr 0x3FFF + 1 gives 0x0000.

Test Plan:
- Reset then PPUADDR 0x21, 0x08 -> t = v = 0x2108, w = 0; O_vid_addr = 0x2108; O_t = 0x2108.
- PPUCTRL 0x04, PPUDATA write 0xAB at v = 0x2000 -> one-cycle O_vid_wren at the first I_tick with addr 0x2000 and data 0xAB; v = 0x2020 after the second tick; O_busy falls.
- Preload memory 0x2400 = 0x5A; PPUADDR 0x24, 0x00; read twice (waiting !O_busy) -> first read presents stale 0x00, then O_rd_buffer = 0x5A; v = 0x2402 with inc32 = 0.
- PPUSCROLL 0x7D, 0x5E -> fine_x = 5, t[4:0] = 0x0F, t[14:12] = 6, t[9:5] = 0x0B, w = 0. A PPUADDR first write followed by I_rd_stat, then PPUADDR 0x3F -> w = 1 and t[13:8] = 0x3F.
- Second PPUDATA write while O_busy -> O_overrun pulses once, a single wren only, v increments once.
- v = 0x3FFF, PPUDATA write -> O_vid_addr 0x3FFF during wren, then v = 0x4000 and O_vid_addr = 0x0000. Reset asserted in ARM -> no wren, v unchanged at 0.
